// File: rtl/pixel_packer_axis_pkg.sv
// Shared definitions for the pixel packer: pixel format encodings and per-format byte counts.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package pixel_pkg;

  // Pixel format encodings as carried on the mode input. Encoding 3 is
  // reserved and falls back to RGB888 everywhere it is decoded.
  localparam logic [1:0] PIX_RGB888   = 2'd0;
  localparam logic [1:0] PIX_RGBX8888 = 2'd1;
  localparam logic [1:0] PIX_RGB565   = 2'd2;

  // Largest number of bytes a single pixel can contribute.
  localparam int MAX_BPP = 4;

  // Formatted pixel: element 0 is the lowest-address byte on the stream.
  typedef logic [MAX_BPP-1:0][7:0] pix_bytes_t;

  // Bytes emitted per pixel for a given format.
  function automatic logic [2:0] bytes_per_pixel(input logic [1:0] mode);
    case (mode)
      PIX_RGBX8888: return 3'd4;
      PIX_RGB565:   return 3'd2;
      default:      return 3'd3;
    endcase
  endfunction

endpackage

// File: rtl/pixel_packer_axis_formatter.sv
// Formats one RGB pixel into up to four stream bytes plus a byte count.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is consumed.
//
// Ports:
//   mode      pixel format (pixel_pkg encodings, 3 decodes as RGB888)
//   r, g, b   pixel colour components
//   pix_bytes formatted bytes, element 0 is sent first
//   bpp       number of valid bytes in pix_bytes (2, 3 or 4)
module pixel_formatter
  import pixel_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output pix_bytes_t pix_bytes,
  output logic [2:0] bpp
);

  logic [15:0] rgb565;

  always_comb begin
    rgb565    = {r[7:3], g[7:2], b[7:3]};
    bpp       = bytes_per_pixel(mode);
    pix_bytes = '0;
    case (mode)
      // Padding byte is forced to zero so the DMA sees a clean X channel.
      PIX_RGBX8888: pix_bytes = {8'h00, r, b, g};
      // 16-bit word goes out little-endian: low byte first.
      PIX_RGB565:   pix_bytes = {16'h0000, rgb565};
      default:      pix_bytes = {8'h00, r, b, g};
    endcase
  end

endmodule

// File: rtl/pixel_packer_axis.sv
// Packs formatted RGB pixels into OUT_BYTES-wide AXI4-Stream words with tlast/tuser framing.
// Latency: a word is registered out the cycle after the accumulator holds it, i.e. tvalid rises the cycle after the completing pixel is taken.
// Backpressure: in_stream_ready falls when the accumulator cannot absorb another pixel or while a line end drains; output holds stable under tready=0.
//
// Ports:
//   aclk, aresetn           clock, asynchronous active-low reset
//   mode                    pixel format, sampled only on an accepted sof pixel
//   r, g, b, valid, sof, eol  pixel input; accepted when valid && in_stream_ready
//   in_stream_ready         pixel input ready (combinational from out_stream_tready)
//   out_stream_*            AXI4-Stream master, byte 0 in tdata[7:0]
module pixel_packer_axis
  import pixel_pkg::*;
#(
  parameter int OUT_BYTES = 4,
  parameter int FILL_W    = $clog2(2*OUT_BYTES)+1
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [1:0]             mode,
  input  logic [7:0]             r,
  input  logic [7:0]             g,
  input  logic [7:0]             b,
  input  logic                   valid,
  output logic                   in_stream_ready,
  input  logic                   sof,
  input  logic                   eol,
  output logic [8*OUT_BYTES-1:0] out_stream_tdata,
  output logic [OUT_BYTES-1:0]   out_stream_tkeep,
  output logic                   out_stream_tlast,
  output logic                   out_stream_tuser,
  output logic                   out_stream_tvalid,
  input  logic                   out_stream_tready
);

  localparam int              ACC_BYTES = 2*OUT_BYTES;
  localparam logic [FILL_W-1:0] OB_F    = FILL_W'(OUT_BYTES);

  // Accumulator: byte 0 is the oldest byte, fill_q counts valid bytes.
  logic [ACC_BYTES-1:0][7:0] acc_q;
  logic [ACC_BYTES-1:0][7:0] acc_shift;
  logic [ACC_BYTES-1:0][7:0] acc_d;
  logic [FILL_W-1:0]         fill_q;
  logic [FILL_W-1:0]         fill_d;
  logic                      eol_pending_q;
  logic                      sof_pending_q;
  logic [1:0]                mode_q;

  logic [1:0]                pix_mode;
  pix_bytes_t                pix_bytes;
  logic [2:0]                bpp;

  logic                      slot_free;
  logic                      drain;
  logic                      accept;
  logic                      accept_sof;
  logic [FILL_W-1:0]         take;
  logic [FILL_W-1:0]         rem;
  logic [FILL_W-1:0]         base;
  logic [FILL_W-1:0]         off;

  logic [OUT_BYTES-1:0][7:0] word_dat;
  logic [OUT_BYTES-1:0]      word_keep;

  // An accepted sof pixel is already formatted in its own mode.
  assign pix_mode = sof ? mode : mode_q;

  pixel_formatter u_formatter (
    .mode      (pix_mode),
    .r         (r),
    .g         (g),
    .b         (b),
    .pix_bytes (pix_bytes),
    .bpp       (bpp)
  );

  // Drain a full word, or the leftover of a finished line, whenever the
  // output register is empty or being emptied this cycle.
  assign slot_free = !out_stream_tvalid || out_stream_tready;
  assign drain     = slot_free && ((fill_q >= OB_F) || (eol_pending_q && (fill_q != '0)));
  assign take      = !drain ? '0 : ((fill_q >= OB_F) ? OB_F : fill_q);
  assign rem       = fill_q - take;

  // After this cycle's drain fewer than OUT_BYTES bytes remain, so one more
  // pixel (at most MAX_BPP <= OUT_BYTES bytes) always fits in 2*OUT_BYTES.
  // While a line end is pending, input stalls so the line closes cleanly.
  assign in_stream_ready = aresetn && !eol_pending_q && (rem < OB_F);
  assign accept          = valid && in_stream_ready;
  assign accept_sof      = accept && sof;

  // New pixel lands right after the surviving bytes; a frame start throws
  // away any partial line and restarts at byte 0.
  assign base = accept_sof ? '0 : rem;

  always_comb begin
    acc_shift = acc_q >> {take, 3'b000};
    acc_d     = acc_shift;
    off       = '0;
    for (int j = 0; j < ACC_BYTES; j++) begin
      off = FILL_W'(j) - base;
      if (accept && (FILL_W'(j) >= base) && (off < FILL_W'(bpp))) begin
        acc_d[j] = pix_bytes[off[1:0]];
      end
    end
  end

  assign fill_d = accept ? (base + FILL_W'(bpp)) : rem;

  // Outgoing word: lowest `take` bytes, unused lanes forced to zero.
  always_comb begin
    for (int i = 0; i < OUT_BYTES; i++) begin
      word_keep[i] = (FILL_W'(i) < take);
      word_dat[i]  = word_keep[i] ? acc_q[i] : 8'h00;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc_q             <= '0;
      fill_q            <= '0;
      eol_pending_q     <= 1'b0;
      sof_pending_q     <= 1'b0;
      mode_q            <= PIX_RGB888;
      out_stream_tdata  <= '0;
      out_stream_tkeep  <= '0;
      out_stream_tlast  <= 1'b0;
      out_stream_tuser  <= 1'b0;
      out_stream_tvalid <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;

      if (accept_sof) begin
        mode_q <= mode;
      end

      // Setting wins: the eol pixel cannot arrive while a line end is pending,
      // but a regular drain emptying the buffer may coincide with it.
      if (accept && eol) begin
        eol_pending_q <= 1'b1;
      end else if (drain && (rem == '0)) begin
        eol_pending_q <= 1'b0;
      end

      // A word drained alongside a new sof belongs to the old frame, so the
      // flag set by this sof must survive that drain.
      if (accept_sof) begin
        sof_pending_q <= 1'b1;
      end else if (drain) begin
        sof_pending_q <= 1'b0;
      end

      if (drain) begin
        out_stream_tdata  <= word_dat;
        out_stream_tkeep  <= word_keep;
        out_stream_tlast  <= eol_pending_q && (rem == '0);
        out_stream_tuser  <= sof_pending_q;
        out_stream_tvalid <= 1'b1;
      end else if (out_stream_tready) begin
        out_stream_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_packer_axis.sv
// Testbench for pixel_packer_axis: OUT_BYTES=4 and OUT_BYTES=8 instances with scoreboard checking.
// Latency: n/a.
// Backpressure: tready driven constant or with a repeating 1-0-0-1 pattern.
module tb_pixel_packer_axis;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } word_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [1:0] mode;
    logic       sof;
    logic       eol;
  } px_t;

  typedef struct packed {
    px_t   px;
    logic  has_exp;
    word_t exp;
  } vec_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  r = 8'h0, g = 8'h0, b = 8'h0;
  logic        sof = 1'b0, eol = 1'b0;
  logic        valid4 = 1'b0, valid8 = 1'b0;
  logic        tready = 1'b0;

  logic        rdy4, rdy8;
  logic [31:0] tdata4;
  logic [3:0]  tkeep4;
  logic        tlast4, tuser4, tvalid4;
  logic [63:0] tdata8;
  logic [7:0]  tkeep8;
  logic        tlast8, tuser8, tvalid8;

  int errors = 0;
  int checks = 0;

  always #5 aclk = ~aclk;

  pixel_packer_axis #(.OUT_BYTES(4)) dut4 (
    .aclk(aclk), .aresetn(aresetn), .mode(mode), .r(r), .g(g), .b(b),
    .valid(valid4), .in_stream_ready(rdy4), .sof(sof), .eol(eol),
    .out_stream_tdata(tdata4), .out_stream_tkeep(tkeep4),
    .out_stream_tlast(tlast4), .out_stream_tuser(tuser4),
    .out_stream_tvalid(tvalid4), .out_stream_tready(tready)
  );

  pixel_packer_axis #(.OUT_BYTES(8)) dut8 (
    .aclk(aclk), .aresetn(aresetn), .mode(mode), .r(r), .g(g), .b(b),
    .valid(valid8), .in_stream_ready(rdy8), .sof(sof), .eol(eol),
    .out_stream_tdata(tdata8), .out_stream_tkeep(tkeep8),
    .out_stream_tlast(tlast8), .out_stream_tuser(tuser8),
    .out_stream_tvalid(tvalid8), .out_stream_tready(tready)
  );

  task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // tready generator: 0 = held low, 1 = held high, 2 = repeating 1,0,0,1
  int tr_mode = 0;
  int unsigned cyc = 0;
  always @(posedge aclk) begin
    #1;
    cyc = cyc + 1;
    case (tr_mode)
      0:       tready = 1'b0;
      2:       tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: tready = 1'b1;
    endcase
  end

  // Scoreboard queues and output monitors
  word_t exp4[$];
  word_t exp8[$];
  word_t cur4, cur8, held4, held8, last4;
  bit    held4_v = 0, held8_v = 0;

  assign cur4 = {32'h0, tdata4, 4'h0, tkeep4, tlast4, tuser4};
  assign cur8 = {tdata8, tkeep8, tlast8, tuser8};

  always @(negedge aclk) begin
    if (!aresetn) begin
      held4_v = 0;
    end else if (tvalid4) begin
      if (held4_v) chk("hold4", cur4, held4);
      if (tready) begin
        if (exp4.size() == 0) chk("unexpected_word4", cur4, '0);
        else                  chk("word4", cur4, exp4.pop_front());
        last4   = cur4;
        held4_v = 0;
      end else begin
        held4   = cur4;
        held4_v = 1;
      end
    end else begin
      if (held4_v) chk("hold4_vld", {79'h0, tvalid4}, 80'h1);
      held4_v = 0;
    end
  end

  always @(negedge aclk) begin
    if (!aresetn) begin
      held8_v = 0;
    end else if (tvalid8) begin
      if (held8_v) chk("hold8", cur8, held8);
      if (tready) begin
        if (exp8.size() == 0) chk("unexpected_word8", cur8, '0);
        else                  chk("word8", cur8, exp8.pop_front());
        held8_v = 0;
      end else begin
        held8   = cur8;
        held8_v = 1;
      end
    end else begin
      if (held8_v) chk("hold8_vld", {79'h0, tvalid8}, 80'h1);
      held8_v = 0;
    end
  end

  // Reference model of the packing behaviour
  bit         use_model = 0;
  logic [7:0] mb[$];
  bit         msof = 0;
  logic [1:0] mreg4 = 2'd0, mreg8 = 2'd0;

  task automatic push_exp(input bit w8, input word_t w);
    if (w8) exp8.push_back(w);
    else    exp4.push_back(w);
  endtask

  task automatic model_accept(input bit w8, input px_t p);
    int         ob;
    int         n;
    logic [1:0] m;
    logic [15:0] c;
    word_t      w;
    ob = w8 ? 8 : 4;
    if (p.sof) begin
      if (w8) mreg8 = (p.mode == 2'd3) ? 2'd0 : p.mode;
      else    mreg4 = (p.mode == 2'd3) ? 2'd0 : p.mode;
      mb.delete();
      msof = 1;
    end
    m = w8 ? mreg8 : mreg4;
    case (m)
      2'd1: begin mb.push_back(p.g); mb.push_back(p.b); mb.push_back(p.r); mb.push_back(8'h00); end
      2'd2: begin
        c = {p.r[7:3], p.g[7:2], p.b[7:3]};
        mb.push_back(c[7:0]); mb.push_back(c[15:8]);
      end
      default: begin mb.push_back(p.g); mb.push_back(p.b); mb.push_back(p.r); end
    endcase
    while (mb.size() >= ob) begin
      w = '0;
      for (int i = 0; i < ob; i++) begin
        w.data[8*i +: 8] = mb.pop_front();
        w.keep[i] = 1'b1;
      end
      w.last = p.eol && (mb.size() == 0);
      w.user = msof;
      msof = 0;
      push_exp(w8, w);
    end
    if (p.eol && (mb.size() != 0)) begin
      w = '0;
      n = mb.size();
      for (int i = 0; i < n; i++) begin
        w.data[8*i +: 8] = mb.pop_front();
        w.keep[i] = 1'b1;
      end
      w.last = 1'b1;
      w.user = msof;
      msof = 0;
      push_exp(w8, w);
    end
  endtask

  // Drive one pixel until accepted (bounded); returns the number of stall cycles.
  task automatic send(input bit w8, input px_t p, output int waits);
    r = p.r; g = p.g; b = p.b; mode = p.mode; sof = p.sof; eol = p.eol;
    valid4 = !w8; valid8 = w8;
    waits = 0;
    forever begin
      @(negedge aclk);
      if ((w8 ? rdy8 : rdy4) === 1'b1) break;
      waits++;
      if (waits > 100) begin
        chk("send_timeout", 80'(waits), 80'h0);
        break;
      end
    end
    if (use_model && waits <= 100) model_accept(w8, p);
    @(posedge aclk);
    #1;
    valid4 = 1'b0; valid8 = 1'b0; sof = 1'b0; eol = 1'b0;
  endtask

  task automatic drain_wait();
    for (int i = 0; i < 300; i++) begin
      if (exp4.size() == 0 && exp8.size() == 0) break;
      @(negedge aclk);
    end
    repeat (3) @(negedge aclk);
    chk("queue4_empty", 80'(exp4.size()), 80'h0);
    chk("queue8_empty", 80'(exp8.size()), 80'h0);
  endtask

  function automatic px_t mkpx(input logic [7:0] rr, gg, bb, input logic [1:0] mm,
                               input logic s, e);
    px_t p;
    p.r = rr; p.g = gg; p.b = bb; p.mode = mm; p.sof = s; p.eol = e;
    return p;
  endfunction

  function automatic word_t mkw(input logic [63:0] d, input logic [7:0] k,
                                input logic l, u);
    word_t w;
    w.data = d; w.keep = k; w.last = l; w.user = u;
    return w;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t1[4];
    vec_t t3[4];
    int   w;
    bit   seen;
    int   len, nlines;
    logic [1:0] fm;

    // RGB888 line on the 4-byte packer
    t1[0] = '{mkpx(8'h01, 8'h02, 8'h03, 2'd0, 1'b1, 1'b0), 1'b0, '0};
    t1[1] = '{mkpx(8'h11, 8'h12, 8'h13, 2'd0, 1'b0, 1'b0), 1'b1, mkw(64'h12010302, 8'hF, 1'b0, 1'b1)};
    t1[2] = '{mkpx(8'h21, 8'h22, 8'h23, 2'd0, 1'b0, 1'b0), 1'b1, mkw(64'h23221113, 8'hF, 1'b0, 1'b0)};
    t1[3] = '{mkpx(8'h31, 8'h32, 8'h33, 2'd0, 1'b0, 1'b1), 1'b1, mkw(64'h31333221, 8'hF, 1'b1, 1'b0)};
    // RGB565 line on the 8-byte packer
    t3[0] = '{mkpx(8'hFF, 8'h00, 8'hFF, 2'd2, 1'b1, 1'b0), 1'b0, '0};
    t3[1] = '{mkpx(8'hFF, 8'h00, 8'hFF, 2'd2, 1'b0, 1'b0), 1'b0, '0};
    t3[2] = '{mkpx(8'hFF, 8'h00, 8'hFF, 2'd2, 1'b0, 1'b0), 1'b0, '0};
    t3[3] = '{mkpx(8'hFF, 8'h00, 8'hFF, 2'd2, 1'b0, 1'b1), 1'b1, mkw(64'hF81FF81FF81FF81F, 8'hFF, 1'b1, 1'b1)};

    // Reset state
    #2;
    chk("rst_tvalid4", {79'h0, tvalid4}, 80'h0);
    chk("rst_tkeep4",  {76'h0, tkeep4}, 80'h0);
    chk("rst_tdata4",  {48'h0, tdata4}, 80'h0);
    chk("rst_flags4",  {78'h0, tlast4, tuser4}, 80'h0);
    chk("rst_rdy4",    {79'h0, rdy4}, 80'h0);
    chk("rst_tvalid8", {79'h0, tvalid8}, 80'h0);
    chk("rst_rdy8",    {79'h0, rdy8}, 80'h0);
    tr_mode = 1;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;

    // Full RGB888 line: ready must never stall
    use_model = 0;
    for (int i = 0; i < 4; i++) begin
      if (t1[i].has_exp) exp4.push_back(t1[i].exp);
      send(1'b0, t1[i].px, w);
      chk("t1_rdy_stall", 80'(w), 80'h0);
    end
    drain_wait();

    // RGB565 on the 8-byte packer
    for (int i = 0; i < 4; i++) begin
      if (t3[i].has_exp) exp8.push_back(t3[i].exp);
      send(1'b1, t3[i].px, w);
    end
    drain_wait();

    // 5-pixel RGB888 line: input blocked from eol acceptance to tlast
    use_model = 1;
    for (int i = 0; i < 5; i++)
      send(1'b0, mkpx(8'(8'h40 + i), 8'(8'h50 + i), 8'(8'h60 + i), 2'd0, i == 0, i == 4), w);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (tvalid4 && tlast4) begin seen = 1; break; end
      chk("eol_block_rdy", {79'h0, rdy4}, 80'h0);
    end
    chk("eol_tlast_seen", {79'h0, seen}, 80'h1);
    chk("eol_last_keep", {76'h0, tkeep4}, 80'h7);
    drain_wait();

    // sof mid-line with two stale bytes, switching to RGBX8888
    send(1'b0, mkpx(8'h40, 8'h41, 8'h42, 2'd0, 1'b1, 1'b0), w);
    send(1'b0, mkpx(8'h50, 8'h51, 8'h52, 2'd0, 1'b0, 1'b0), w);
    send(1'b0, mkpx(8'hA1, 8'hA2, 8'hA3, 2'd1, 1'b1, 1'b1), w);
    drain_wait();
    chk("sof_midline_word", last4, mkw(64'h00A1A3A2, 8'hF, 1'b1, 1'b1));

    // Random frames under 1-0-0-1 backpressure with random idle cycles;
    // mode changes on non-sof pixels must be ignored.
    tr_mode = 2;
    for (int d = 0; d < 2; d++) begin
      for (int f = 0; f < 6; f++) begin
        fm = 2'($urandom_range(0, 3));
        nlines = $urandom_range(1, 2);
        for (int l = 0; l < nlines; l++) begin
          len = $urandom_range(1, 7);
          for (int p = 0; p < len; p++) begin
            if ($urandom_range(0, 2) == 0) begin @(posedge aclk); #1; end
            send(d == 1,
                 mkpx(8'($urandom), 8'($urandom), 8'($urandom),
                      (l == 0 && p == 0) ? fm : 2'($urandom_range(0, 3)),
                      l == 0 && p == 0, p == len - 1), w);
          end
        end
      end
      drain_wait();
    end

    // Reset while a word is stalled and five bytes are buffered
    tr_mode = 0;
    use_model = 0;
    @(posedge aclk); #1;
    send(1'b0, mkpx(8'h01, 8'h02, 8'h03, 2'd0, 1'b1, 1'b0), w);
    send(1'b0, mkpx(8'h11, 8'h12, 8'h13, 2'd0, 1'b0, 1'b0), w);
    send(1'b0, mkpx(8'h21, 8'h22, 8'h23, 2'd0, 1'b0, 1'b0), w);
    @(negedge aclk);
    chk("pre_rst_tvalid", {79'h0, tvalid4}, 80'h1);
    chk("pre_rst_rdy", {79'h0, rdy4}, 80'h0);
    #2 aresetn = 1'b0;
    #1;
    chk("async_rst_tvalid", {79'h0, tvalid4}, 80'h0);
    chk("async_rst_tkeep", {76'h0, tkeep4}, 80'h0);
    chk("async_rst_rdy", {79'h0, rdy4}, 80'h0);
    exp4.delete();
    mb.delete();
    tr_mode = 1;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;
    for (int i = 0; i < 4; i++) begin
      if (t1[i].has_exp) exp4.push_back(t1[i].exp);
      send(1'b0, t1[i].px, w);
      chk("post_rst_rdy_stall", 80'(w), 80'h0);
    end
    drain_wait();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_packer_axis.md
Name: pixel_packer_axis

Overview:
Parametrised pixel-to-AXI4-Stream packer for the ray-marcher video output. It accepts one RGB pixel per cycle, formats it in one of three runtime-selectable pixel formats, and packs the bytes into OUT_BYTES-wide stream words. It emits fully registered, AXI-compliant words with tlast/tuser framing and partial-word flush at end of line. It sits between the pixel generator and the video DMA/VDMA, and replaces the fixed 24-bit/32-bit packer.

Parameters:
OUT_BYTES, 4, output word width in bytes. Legal values: 4 or 8.
FILL_W, $clog2(2*OUT_BYTES)+1, width of the internal byte-fill counter. Derived; not to be overridden.

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
mode  in  2  pixel format: 0=RGB888 (3 B/px), 1=RGBX8888 (4 B/px), 2=RGB565 (2 B/px), 3=reserved (treated as 0). Sampled only on an accepted sof pixel.
r, g, b  in  8 each  pixel colour
valid  in  1  pixel valid
in_stream_ready  out  1  pixel accepted when valid && in_stream_ready
sof  in  1  first pixel of frame
eol  in  1  last pixel of line
out_stream_tdata  out  8*OUT_BYTES  packed bytes; byte0 in bits [7:0]
out_stream_tkeep  out  OUT_BYTES  byte enables
out_stream_tlast  out  1  last word of line
out_stream_tuser  out  1  first word of frame
out_stream_tvalid  out  1
out_stream_tready  in  1

Behaviour:
- Reset (async assert, sync release): tvalid/tlast/tuser=0, tkeep=0, tdata=0, fill=0, eol_pending=0, sof_pending=0, mode_reg=0. in_stream_ready=0 while aresetn=0.
- Byte order per pixel, lowest address first:
  - RGB888: G, B, R.
  - RGBX8888: G, B, R, 0x00.
  - RGB565: word {r[7:3], g[7:2], b[7:3]}, sent little-endian.
- Accumulator is a 2*OUT_BYTES byte shift buffer with fill count. An accepted pixel appends bpp bytes at position fill.
- Drain: when the output slot is free (!tvalid || tready) and either (a) fill>=OUT_BYTES, or (b) eol_pending && fill>0:
  - load the lowest min(fill,OUT_BYTES) bytes into the output register, shift the rest down, fill -= taken.
  - tkeep has one bit set per valid byte from bit 0 upward; unused tdata bytes are 0.
  - tlast=1 iff eol_pending and the remainder after this drain is 0. eol_pending clears on that drain.
- Output register holds tdata/tkeep/tlast/tuser stable while tvalid && !tready.
- in_stream_ready = aresetn && !eol_pending && (fill - (drain ? OUT_BYTES : 0)) < OUT_BYTES.
  - Combinational from out_stream_tready; no other combinational input-to-output path.
  - Sustains 1 pixel/cycle in all modes when tready is held high.
- Latency: a word appears (tvalid=1) on the cycle after the pixel that completes it is accepted.
- eol accepted: sets eol_pending and blocks input until the line is fully drained. This takes one or two words; e.g. RGB888 with fill 3+3 produces a full word, then a 2-byte tlast word.
- sof accepted:
  - latches mode into mode_reg; that pixel already uses the new mode.
  - any residual bytes with fill>0 and !eol_pending are discarded, and the pixel is written at byte 0.
  - sets sof_pending; the next drained word carries tuser=1 and clears sof_pending.
- sof and eol on the same pixel: a single-pixel line; both flags apply to one word.
- Mode changes without sof are ignored.

Decomposition:
- Shared package pixel_pkg holds:
  - mode encodings PIX_RGB888, PIX_RGBX8888, PIX_RGB565.
  - function bytes_per_pixel(mode).
  - constant MAX_BPP=4.
- Sub-module pixel_formatter: combinational; mode+r,g,b -> 4-byte vector + bpp.
- The accumulator/drain logic and output register stay in the top level.

Test Plan:
- OUT_BYTES=4, RGB888, tready=1: px (01,02,03),(11,12,13),(21,22,23),(31,32,33 eol), sof on px0 -> 3 words 0x12010302, 0x23221113, 0x31333221. tkeep=0xF; tuser on word0 only; tlast on word2; ready never drops.
- RGB888, 5-px line (eol on px4) -> 4 words; last word tkeep=0x7, tlast=1. in_stream_ready low from eol acceptance until the tlast handshake.
- OUT_BYTES=8, RGB565: px r=0xFF,g=0x00,b=0xFF repeated 4, eol -> one word 0xF81FF81FF81FF81F, tkeep=0xFF, tlast=1.
- Backpressure: tready toggled 1-0-0-1 with random valid -> tdata/tkeep/tlast/tuser stable while stalled; byte stream identical to the tready=1 run; no pixel lost or duplicated.
- sof mid-line with fill=2 in RGB888, mode switched to RGBX8888 on that sof -> stale bytes dropped. Next word = G,B,R,00 of the sof px, with tuser=1.
- aresetn asserted while tvalid=1 and fill=5 -> tvalid drops immediately and fill=0. After release, the first sof line packs correctly from byte 0.
